// File: rtl/ser_par_if.sv
// Handshake and serial/parallel bundle for ser_par_conv.
// master drives stimulus; slave is the converter side.
interface ser_par_if #(
  parameter int WIDTH = 8
);
  logic             mode;
  logic             dir;
  logic             en;
  logic             sin;
  logic [WIDTH-1:0] par_out;
  logic             par_out_valid;
  logic             par_out_ready;
  logic [WIDTH-1:0] par_in;
  logic             par_in_valid;
  logic             par_in_ready;
  logic             sout;
  logic             sout_valid;
  logic             overrun;
  logic             clr_ovr;

  modport master (
    output mode, dir, en, sin,
    output par_out_ready, par_in,
    output par_in_valid, clr_ovr,
    input  par_out, par_out_valid,
    input  par_in_ready, sout,
    input  sout_valid, overrun
  );

  modport slave (
    input  mode, dir, en, sin,
    input  par_out_ready, par_in,
    input  par_in_valid, clr_ovr,
    output par_out, par_out_valid,
    output par_in_ready, sout,
    output sout_valid, overrun
  );
endinterface

// File: rtl/ser_par_conv.sv
// Bidirectional serial/parallel converter sharing one shift register.
// mode/dir are sampled only at word start and held for the word.
module ser_par_conv #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rstn,
  ser_par_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pov_q, pov_d;
  logic             ovr_q, ovr_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;

  logic             word_start;
  logic             m_eff;
  logic             d_eff;
  logic             last;
  logic             hs;
  logic [CW-1:0]    cnt_inc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      po_q    <= '0;
      cnt_q   <= '0;
      pov_q   <= 1'b0;
      ovr_q   <= 1'b0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      po_q    <= po_d;
      cnt_q   <= cnt_d;
      pov_q   <= pov_d;
      ovr_q   <= ovr_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    po_d    = po_q;
    cnt_d   = cnt_q;
    pov_d   = pov_q;
    ovr_d   = ovr_q;
    mode_d  = mode_q;
    dir_d   = dir_q;

    word_start = (cnt_q == '0) && (state_q == IDLE);
    m_eff   = word_start ? io.mode : mode_q;
    d_eff   = word_start ? io.dir : dir_q;
    last    = (cnt_q == LAST);
    cnt_inc = last ? '0 : cnt_q + 1'b1;
    hs      = pov_q && io.par_out_ready && !m_eff;

    if (word_start) begin
      mode_d = io.mode;
      dir_d  = io.dir;
    end

    if (!m_eff) begin
      if (hs) pov_d = 1'b0;
      if (io.clr_ovr) ovr_d = 1'b0;
      if (io.en) begin
        sr_d  = d_eff ? {io.sin, sr_q[WIDTH-1:1]}
                      : {sr_q[WIDTH-2:0], io.sin};
        cnt_d = cnt_inc;
        // A completing word may replace one leaving on the same edge.
        if (last) begin
          if (!pov_q || hs) begin
            po_d  = sr_d;
            pov_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.par_in_valid) begin
            sr_d    = io.par_in;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (io.en) begin
            sr_d  = dir_q ? {1'b0, sr_q[WIDTH-1:1]}
                          : {sr_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_inc;
            if (last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign io.par_out       = po_q;
  assign io.par_out_valid = pov_q;
  assign io.overrun       = ovr_q;
  assign io.par_in_ready  = m_eff && (state_q == IDLE);
  assign io.sout_valid    = (state_q == SHIFT);
  assign io.sout          = (state_q == SHIFT) &&
                            (dir_q ? sr_q[0] : sr_q[WIDTH-1]);
endmodule
